// File: rtl/rx_frame_writer_if.sv
// Byte-wide receive stream from the MAC into the frame writer.
// master = MAC side, slave = frame writer.
interface rx_frame_writer_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/rx_frame_writer.sv
// Receive-side writer: packs good MAC frames into fixed-size buffer slots via the
// 16-bit port, reports commits, and tracks a ring of filled slots released by the CPU.
module rx_frame_writer #(
    parameter int SLOT_W    = 3,
    parameter int SLOT_HW_W = 10,
    parameter int MAX_BYTES = 1536,
    parameter int MIN_BYTES = 14
) (
    input  logic                        clk,
    input  logic                        rst,
    rx_frame_writer_if.slave            s_axis,
    output logic [SLOT_W+SLOT_HW_W-1:0] mem_addr,
    output logic [15:0]                 mem_din,
    output logic [1:0]                  mem_we,
    output logic                        mem_en,
    output logic                        done_valid,
    output logic [SLOT_W-1:0]           done_slot,
    output logic [SLOT_HW_W:0]          done_len,
    output logic [SLOT_W-1:0]           rd_slot,
    output logic [SLOT_W:0]             fill_count,
    input  logic                        release_i,
    output logic [15:0]                 drop_count
);
    localparam int BW = SLOT_HW_W + 1;
    localparam logic [BW-1:0]   MAX_LEN = BW'(MAX_BYTES);
    localparam logic [BW-1:0]   MIN_LEN = BW'(MIN_BYTES);
    localparam logic [SLOT_W:0] FULL    = (SLOT_W+1)'(1 << SLOT_W);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t                        state_q, state_d;
    logic [BW-1:0]                 bcnt_q, bcnt_d;
    logic [SLOT_W-1:0]             wr_slot_q, wr_slot_d;
    logic [SLOT_W-1:0]             rd_slot_q, rd_slot_d;
    logic [SLOT_W:0]               fill_q, fill_d;
    logic [15:0]                   drop_q, drop_d;
    logic [SLOT_W+SLOT_HW_W-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]                   mem_din_q, mem_din_d;
    logic [1:0]                    mem_we_q, mem_we_d;
    logic                          mem_en_q, mem_en_d;
    logic                          done_valid_q, done_valid_d;
    logic [SLOT_W-1:0]             done_slot_q, done_slot_d;
    logic [SLOT_HW_W:0]            done_len_q, done_len_d;

    logic          beat, wr, close, commit, drop_frame, rel;
    logic [BW-1:0] wr_off, len;

    // The block never back-pressures the MAC; it only holds off while in reset.
    assign s_axis.tready = ~rst;
    assign beat          = s_axis.tvalid & s_axis.tready;

    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        wr_slot_d    = wr_slot_q;
        rd_slot_d    = rd_slot_q;
        fill_d       = fill_q;
        drop_d       = drop_q;
        mem_addr_d   = '0;
        mem_din_d    = '0;
        mem_we_d     = '0;
        mem_en_d     = 1'b0;
        done_valid_d = 1'b0;
        done_slot_d  = '0;
        done_len_d   = '0;
        wr           = 1'b0;
        close        = 1'b0;
        commit       = 1'b0;
        drop_frame   = 1'b0;
        wr_off       = '0;
        len          = '0;

        if (beat) begin
            case (state_q)
                IDLE: begin
                    if (fill_q == FULL) begin
                        if (s_axis.tlast) drop_frame = 1'b1;
                        else              state_d    = DROP;
                    end else begin
                        wr  = 1'b1;
                        len = BW'(1);
                        if (s_axis.tlast) close = 1'b1;
                        else begin
                            state_d = RECV;
                            bcnt_d  = BW'(1);
                        end
                    end
                end
                RECV: begin
                    // Byte MAX_LEN+1 would overflow the frame limit: stop writing.
                    if (bcnt_q == MAX_LEN) begin
                        if (s_axis.tlast) begin
                            drop_frame = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        wr     = 1'b1;
                        wr_off = bcnt_q;
                        len    = bcnt_q + BW'(1);
                        if (s_axis.tlast) begin
                            close   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            bcnt_d = len;
                        end
                    end
                end
                DROP: begin
                    if (s_axis.tlast) begin
                        drop_frame = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (close) begin
            if (!s_axis.tuser && len >= MIN_LEN && len <= MAX_LEN) commit     = 1'b1;
            else                                                   drop_frame = 1'b1;
        end

        if (wr) begin
            mem_en_d   = 1'b1;
            mem_addr_d = {wr_slot_q, wr_off[BW-1:1]};
            mem_din_d  = {s_axis.tdata, s_axis.tdata};
            mem_we_d   = wr_off[0] ? 2'b10 : 2'b01;
        end

        if (commit) begin
            done_valid_d = 1'b1;
            done_slot_d  = wr_slot_q;
            done_len_d   = len;
            wr_slot_d    = wr_slot_q + SLOT_W'(1);
        end

        rel = release_i && (fill_q != '0);
        if (rel) rd_slot_d = rd_slot_q + SLOT_W'(1);

        case ({commit, rel})
            2'b10:   fill_d = fill_q + (SLOT_W+1)'(1);
            2'b01:   fill_d = fill_q - (SLOT_W+1)'(1);
            default: fill_d = fill_q;
        endcase

        if (drop_frame && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bcnt_q       <= '0;
            wr_slot_q    <= '0;
            rd_slot_q    <= '0;
            fill_q       <= '0;
            drop_q       <= '0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_we_q     <= '0;
            mem_en_q     <= 1'b0;
            done_valid_q <= 1'b0;
            done_slot_q  <= '0;
            done_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            wr_slot_q    <= wr_slot_d;
            rd_slot_q    <= rd_slot_d;
            fill_q       <= fill_d;
            drop_q       <= drop_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_we_q     <= mem_we_d;
            mem_en_q     <= mem_en_d;
            done_valid_q <= done_valid_d;
            done_slot_q  <= done_slot_d;
            done_len_q   <= done_len_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_we     = mem_we_q;
    assign mem_en     = mem_en_q;
    assign done_valid = done_valid_q;
    assign done_slot  = done_slot_q;
    assign done_len   = done_len_q;
    assign rd_slot    = rd_slot_q;
    assign fill_count = fill_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_rx_frame_writer.sv
// Self-checking bench for rx_frame_writer: vector table, hand-written corner
// sequences, and random frames checked against a frame-level reference model.
module tb_rx_frame_writer;
    localparam int MAXB = 1536;
    localparam int MINB = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_frame_writer_if s_axis();
    logic [12:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_we;
    logic        mem_en, done_valid, release_i;
    logic [2:0]  done_slot, rd_slot;
    logic [10:0] done_len;
    logic [3:0]  fill_count;
    logic [15:0] drop_count;

    rx_frame_writer dut (
        .clk(clk), .rst(rst), .s_axis(s_axis),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_en(mem_en),
        .done_valid(done_valid), .done_slot(done_slot), .done_len(done_len),
        .rd_slot(rd_slot), .fill_count(fill_count), .release_i(release_i),
        .drop_count(drop_count)
    );

    typedef struct { int cyc; logic [12:0] addr; logic [15:0] din; logic [1:0] we; } wr_t;
    typedef struct { int cyc; logic [2:0] slot; logic [10:0] len; } dn_t;
    typedef struct { int len; bit tuser; int commit; int slot; int fill; int drop; } vec_t;

    wr_t act_w[$], exp_w[$];
    dn_t act_d[$], exp_d[$];
    int  cyc = 0;
    int  checks = 0, errors = 0;
    // Reference model: ring state at frame granularity.
    int  m_fill = 0, m_wr = 0, m_rd = 0, m_drop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_en === 1'b1)     act_w.push_back('{cyc, mem_addr, mem_din, mem_we});
        if (done_valid === 1'b1) act_d.push_back('{cyc, done_slot, done_len});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; s_axis.tuser = 1'b0; release_i = 1'b0;
        end
    endtask

    task automatic model_release();
        if (m_fill > 0) begin m_fill--; m_rd = (m_rd + 1) % 8; end
    endtask

    task automatic release_pulse();
        @(negedge clk);
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; release_i = 1'b1;
        model_release();
        idle(1);
    endtask

    // Drives one frame; the model records the writes and commit it implies.
    task automatic send_frame(input int len, input bit tuser, input int seed,
                              input int rel_at, input bit gaps);
        bit accepted;
        logic [7:0] b;
        accepted = (m_fill < 8);
        for (int i = 0; i < len; i++) begin
            if (gaps) while ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                s_axis.tvalid = 1'b0; s_axis.tdata = 8'($urandom); release_i = 1'b0;
            end
            @(negedge clk);
            b = 8'((seed + i) & 255);
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = b;
            s_axis.tlast  = (i == len - 1);
            s_axis.tuser  = (i == len - 1) ? tuser : 1'($urandom);
            release_i     = (i == rel_at);
            if (i == rel_at) model_release();
            if (accepted && i < MAXB)
                exp_w.push_back('{cyc + 1, {3'(m_wr), 10'(i >> 1)}, {b, b}, (i % 2 == 1) ? 2'b10 : 2'b01});
            if (i == len - 1) begin
                if (accepted && !tuser && len >= MINB && len <= MAXB) begin
                    exp_d.push_back('{cyc + 1, 3'(m_wr), 11'(len)});
                    m_fill++;
                    m_wr = (m_wr + 1) % 8;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
        end
    endtask

    task automatic flush(input string tag);
        int bad;
        idle(3);
        chk({tag, " write count"}, act_w.size(), exp_w.size());
        bad = -1;
        for (int i = 0; i < act_w.size() && i < exp_w.size(); i++)
            if (act_w[i].cyc != exp_w[i].cyc || act_w[i].addr !== exp_w[i].addr ||
                act_w[i].din !== exp_w[i].din || act_w[i].we !== exp_w[i].we) begin
                bad = i; break;
            end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s write %0d: got cyc %0d addr %h din %h we %b expected cyc %0d addr %h din %h we %b",
                     tag, bad, act_w[bad].cyc, act_w[bad].addr, act_w[bad].din, act_w[bad].we,
                     exp_w[bad].cyc, exp_w[bad].addr, exp_w[bad].din, exp_w[bad].we);
        end
        chk({tag, " commit count"}, act_d.size(), exp_d.size());
        bad = -1;
        for (int i = 0; i < act_d.size() && i < exp_d.size(); i++)
            if (act_d[i].cyc != exp_d[i].cyc || act_d[i].slot !== exp_d[i].slot ||
                act_d[i].len !== exp_d[i].len) begin
                bad = i; break;
            end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s commit %0d: got cyc %0d slot %0d len %0d expected cyc %0d slot %0d len %0d",
                     tag, bad, act_d[bad].cyc, act_d[bad].slot, act_d[bad].len,
                     exp_d[bad].cyc, exp_d[bad].slot, exp_d[bad].len);
        end
        chk({tag, " fill_count"}, fill_count, m_fill);
        chk({tag, " rd_slot"}, rd_slot, m_rd);
        chk({tag, " drop_count"}, drop_count, m_drop);
        act_w.delete(); exp_w.delete(); act_d.delete(); exp_d.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " tready"}, s_axis.tready, 0);
        chk({tag, " mem_en"}, mem_en, 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " done_valid"}, done_valid, 0);
        chk({tag, " fill_count"}, fill_count, 0);
        chk({tag, " rd_slot"}, rd_slot, 0);
        chk({tag, " drop_count"}, drop_count, 0);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{64,   1'b0, 1, 0, 1, 0};   // good frame into empty buffer
        tbl[1] = '{60,   1'b1, 0, 0, 1, 1};   // errored frame
        tbl[2] = '{1600, 1'b0, 0, 0, 1, 2};   // oversize
        tbl[3] = '{64,   1'b0, 1, 1, 2, 2};   // slot pointer unaffected by drops
        tbl[4] = '{10,   1'b0, 0, 0, 2, 3};   // runt
        tbl[5] = '{1,    1'b0, 0, 0, 2, 4};   // single beat
        tbl[6] = '{14,   1'b0, 1, 2, 3, 4};   // shortest legal
        tbl[7] = '{13,   1'b0, 0, 0, 3, 5};   // one short
        tbl[8] = '{1536, 1'b0, 1, 3, 4, 5};   // longest legal
        tbl[9] = '{1537, 1'b0, 0, 0, 4, 6};   // one long

        s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tlast = 1'b0; s_axis.tuser = 1'b0;
        release_i = 1'b0;
        rst = 1'b1;
        idle(3);
        check_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("tready after reset", s_axis.tready, 1);
        act_w.delete(); act_d.delete();

        for (int k = 0; k < 10; k++) begin
            send_frame(tbl[k].len, tbl[k].tuser, 0, -1, 1'b0);
            idle(3);
            chk($sformatf("tbl%0d commit", k), act_d.size(), tbl[k].commit);
            if (tbl[k].commit == 1 && act_d.size() > 0)
                chk($sformatf("tbl%0d slot", k), act_d[0].slot, tbl[k].slot);
            chk($sformatf("tbl%0d fill", k), fill_count, tbl[k].fill);
            chk($sformatf("tbl%0d drop", k), drop_count, tbl[k].drop);
            flush($sformatf("tbl%0d", k));
        end

        // Reset part-way through a frame abandons it and clears all state.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            s_axis.tvalid = 1'b1; s_axis.tdata = 8'(i); s_axis.tlast = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1; s_axis.tvalid = 1'b0;
        @(negedge clk);
        check_reset_outputs("midframe reset");
        @(negedge clk) rst = 1'b0;
        m_fill = 0; m_wr = 0; m_rd = 0; m_drop = 0;
        idle(2);
        act_w.delete(); exp_w.delete(); act_d.delete(); exp_d.delete();

        // Nine back-to-back frames: the ninth finds the ring full.
        for (int f = 0; f < 9; f++) send_frame(100, 1'b0, f * 17, -1, 1'b0);
        idle(3);
        chk("full commits", act_d.size(), 8);
        if (act_d.size() > 0) chk("first slot after reset", act_d[0].slot, 0);
        chk("full fill", fill_count, 8);
        chk("full drop", drop_count, 1);
        flush("full");
        release_pulse();
        chk("release fill", fill_count, 7);
        chk("release rd_slot", rd_slot, 1);
        send_frame(100, 1'b0, 5, -1, 1'b0);
        flush("refill");
        chk("refill fill", fill_count, 8);
        // Release during a frame that started full must not rescue it.
        send_frame(50, 1'b0, 9, 10, 1'b0);
        flush("no rescue");
        chk("no rescue fill", fill_count, 7);
        chk("no rescue drop", drop_count, 2);

        // Commit and release in the same cycle at fill 3.
        repeat (4) release_pulse();
        chk("pre-overlap fill", fill_count, 3);
        send_frame(40, 1'b0, 77, 39, 1'b0);
        idle(2);
        chk("overlap fill", fill_count, 3);
        flush("overlap");

        // Random frames against the model.
        for (int n = 0; n < 40; n++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1500, 1600) : $urandom_range(1, 100);
            send_frame(len, ($urandom_range(0, 7) == 0), $urandom_range(0, 255),
                       ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1, 1'b1);
            flush($sformatf("rand%0d", n));
            repeat ($urandom_range(0, 2)) release_pulse();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
